// File: rtl/ahb_apb_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_apb_fsm_ctrl
//
// Purpose:
//   Sequencing controller for the AHB-to-APB bridge. Takes the decoded AHB
//   transfer from the bridge slave interface and runs the APB SETUP/ACCESS
//   handshake. It generates the AHB wait-state signal hreadyout. Writes are
//   posted: the AHB data phase finishes before the APB access starts. One
//   pipelined AHB transfer that arrives while a posted write is being
//   accepted is held in a one-entry pending buffer.
//
// Ports:
//   hclk       bridge clock
//   hresetn    asynchronous active-low reset
//   valid      decoded AHB transfer present in its address phase
//   haddr      AHB address (address phase)
//   hwrite     AHB direction, 1 = write (address phase)
//   temp_sel   one-hot peripheral select decoded from haddr
//   hwdata     AHB write data (data phase)
//   pready     APB completer ready
//   hreadyout  AHB ready to master, 0 = wait state
//   psel       APB one-hot select (registered)
//   penable    APB enable (registered)
//   pwrite     APB direction (registered)
//   paddr      APB address (registered)
//   pwdata     APB write data (registered)
// ---------------------------------------------------------------------------
module ahb_apb_fsm_ctrl #(
   parameter int NSLV   = 3,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              valid,
   input  logic [ADDR_W-1:0] haddr,
   input  logic              hwrite,
   input  logic [NSLV-1:0]   temp_sel,
   input  logic [DATA_W-1:0] hwdata,
   input  logic              pready,
   output logic              hreadyout,
   output logic [NSLV-1:0]   psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WWAIT  = 2'd1;
   localparam logic [1:0] ST_SETUP  = 2'd2;
   localparam logic [1:0] ST_ACCESS = 2'd3;

   logic [1:0]        state;
   logic [ADDR_W-1:0] cur_addr;
   logic [NSLV-1:0]   cur_sel;
   logic              pend_vld;
   logic [ADDR_W-1:0] pend_addr;
   logic              pend_write;
   logic [NSLV-1:0]   pend_sel;
   logic              accept;

   // Wait-state generation. The bridge is ready in IDLE and in the posted
   // write data cycle. It stalls the master during SETUP. In ACCESS it stays
   // ready only for a read that completes this cycle, because the read data
   // is passed through combinationally. A completing write keeps hreadyout
   // low, so no new transfer is taken while the pending slot may still be
   // occupied.
   always_comb begin
      hreadyout = 1'b1;
      case (state)
         ST_IDLE:   hreadyout = 1'b1;
         ST_WWAIT:  hreadyout = 1'b1;
         ST_SETUP:  hreadyout = 1'b0;
         ST_ACCESS: hreadyout = pready & ~pwrite;
         default:   hreadyout = 1'b1;
      endcase
   end

   assign accept = valid & hreadyout;

   // Main sequencer. All APB outputs are registered here. paddr, pwrite
   // and pwdata are loaded only when a transfer enters SETUP, and they keep
   // their last values afterwards. psel and penable drop as soon as the bus
   // goes quiet. cur_* holds the address/select of a posted write while its
   // data phase completes in WWAIT. pend_* holds a transfer the master
   // pipelined during that WWAIT cycle. That transfer is consumed when the
   // write finishes on APB.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state      <= ST_IDLE;
         psel       <= '0;
         penable    <= 1'b0;
         pwrite     <= 1'b0;
         paddr      <= '0;
         pwdata     <= '0;
         cur_addr   <= '0;
         cur_sel    <= '0;
         pend_vld   <= 1'b0;
         pend_addr  <= '0;
         pend_write <= 1'b0;
         pend_sel   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept && !hwrite) begin
                  state   <= ST_SETUP;
                  paddr   <= haddr;
                  pwrite  <= 1'b0;
                  psel    <= temp_sel;
                  penable <= 1'b0;
               end else if (accept && hwrite) begin
                  state    <= ST_WWAIT;
                  cur_addr <= haddr;
                  cur_sel  <= temp_sel;
               end
            end

            ST_WWAIT: begin
               state   <= ST_SETUP;
               paddr   <= cur_addr;
               pwrite  <= 1'b1;
               psel    <= cur_sel;
               pwdata  <= hwdata;
               penable <= 1'b0;
               if (accept) begin
                  pend_vld   <= 1'b1;
                  pend_addr  <= haddr;
                  pend_write <= hwrite;
                  pend_sel   <= temp_sel;
               end
            end

            ST_SETUP: begin
               state   <= ST_ACCESS;
               penable <= 1'b1;
            end

            ST_ACCESS: begin
               if (pready) begin
                  if (!pwrite) begin
                     if (accept && !hwrite) begin
                        state   <= ST_SETUP;
                        paddr   <= haddr;
                        pwrite  <= 1'b0;
                        psel    <= temp_sel;
                        penable <= 1'b0;
                     end else if (accept && hwrite) begin
                        state    <= ST_WWAIT;
                        cur_addr <= haddr;
                        cur_sel  <= temp_sel;
                        psel     <= '0;
                        penable  <= 1'b0;
                     end else begin
                        state   <= ST_IDLE;
                        psel    <= '0;
                        penable <= 1'b0;
                     end
                  end else begin
                     if (pend_vld && !pend_write) begin
                        state    <= ST_SETUP;
                        paddr    <= pend_addr;
                        pwrite   <= 1'b0;
                        psel     <= pend_sel;
                        penable  <= 1'b0;
                        pend_vld <= 1'b0;
                     end else if (pend_vld && pend_write) begin
                        state    <= ST_WWAIT;
                        cur_addr <= pend_addr;
                        cur_sel  <= pend_sel;
                        psel     <= '0;
                        penable  <= 1'b0;
                        pend_vld <= 1'b0;
                     end else begin
                        state   <= ST_IDLE;
                        psel    <= '0;
                        penable <= 1'b0;
                     end
                  end
               end
            end

            default: begin
               state   <= ST_IDLE;
               psel    <= '0;
               penable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_apb_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_fsm_ctrl
//
// Purpose:
//   Self-checking bench for ahb_apb_fsm_ctrl. Directed AHB transfers are
//   driven one cycle at a time. A transfer-queue model predicts every output
//   on each falling edge. Literal expectations in the stimulus pin the
//   important cycles of each scenario.
// ---------------------------------------------------------------------------
module tb_ahb_apb_fsm_ctrl;

   logic        hclk;
   logic        hresetn;
   logic        valid;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  temp_sel;
   logic [31:0] hwdata;
   logic        pready;
   logic        hreadyout;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;

   int checks = 0;
   int errors = 0;

   ahb_apb_fsm_ctrl #(.NSLV(3), .ADDR_W(32), .DATA_W(32)) dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .valid     (valid),
      .haddr     (haddr),
      .hwrite    (hwrite),
      .temp_sel  (temp_sel),
      .hwdata    (hwdata),
      .pready    (pready),
      .hreadyout (hreadyout),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // One accepted AHB transfer as the model sees it.
   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  sel;
      logic [31:0] data;
   } xfer_t;

   // The model keeps a queue of accepted transfers. The head is the one in
   // service, and age counts cycles since it became the head. A write
   // spends age 0 completing its AHB data phase, then it has one setup
   // cycle. A read starts in setup at age 0. Access lasts until pready. The
   // bus outputs are sticky: paddr/pwrite/pwdata show the last transfer
   // that reached setup.
   xfer_t       q[$];
   int          age = 0;
   logic [31:0] lastAddr = 32'h0;
   logic        lastWr = 1'b0;
   logic [31:0] lastData = 32'h0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge. The task returns
   // once registered and combinational outputs have settled for that cycle.
   task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                                input logic [2:0] s, input logic [31:0] d, input logic r);
      @(posedge hclk);
      #1;
      valid    = v;
      hwrite   = w;
      haddr    = a;
      temp_sel = s;
      hwdata   = d;
      pready   = r;
      #1;
   endtask

   // Per-cycle compare against the model, then advance the model with the
   // inputs that the coming rising edge will sample.
   always @(negedge hclk) begin
      logic        inSetup, inAccess, expRdy, expEn, done, acc, wasEmpty;
      logic [2:0]  expSel;
      xfer_t       h;
      xfer_t       n;
      if (!hresetn) begin
         q.delete();
         age      = 0;
         lastAddr = 32'h0;
         lastWr   = 1'b0;
         lastData = 32'h0;
         checkOutput("rst hreadyout", 32'(hreadyout), 32'h1);
         checkOutput("rst psel", 32'(psel), 32'h0);
         checkOutput("rst penable", 32'(penable), 32'h0);
         checkOutput("rst paddr", paddr, 32'h0);
      end else begin
         inSetup  = 1'b0;
         inAccess = 1'b0;
         if (q.size() > 0) begin
            if (q[0].wr) begin
               inSetup  = (age == 1);
               inAccess = (age >= 2);
            end else begin
               inSetup  = (age == 0);
               inAccess = (age >= 1);
            end
         end
         if (inSetup || inAccess) begin
            lastAddr = q[0].addr;
            lastWr   = q[0].wr;
            if (q[0].wr) lastData = q[0].data;
            expSel = q[0].sel;
         end else begin
            expSel = 3'b000;
         end
         expEn = inAccess;
         if (inSetup)       expRdy = 1'b0;
         else if (inAccess) expRdy = pready && !q[0].wr;
         else               expRdy = 1'b1;

         checkOutput("model hreadyout", 32'(hreadyout), 32'(expRdy));
         checkOutput("model psel", 32'(psel), 32'(expSel));
         checkOutput("model penable", 32'(penable), 32'(expEn));
         checkOutput("model pwrite", 32'(pwrite), 32'(lastWr));
         checkOutput("model paddr", paddr, lastAddr);
         checkOutput("model pwdata", pwdata, lastData);

         if (q.size() > 0 && q[0].wr && age == 0) begin
            h      = q[0];
            h.data = hwdata;
            q[0]   = h;
         end
         done     = inAccess && pready;
         acc      = valid && expRdy;
         wasEmpty = (q.size() == 0);
         if (done) void'(q.pop_front());
         if (acc) begin
            n.addr = haddr;
            n.wr   = hwrite;
            n.sel  = temp_sel;
            n.data = 32'h0;
            q.push_back(n);
         end
         if (done || wasEmpty) age = 0;
         else                  age++;
      end
   end

   initial begin
      hresetn  = 1'b0;
      valid    = 1'b0;
      hwrite   = 1'b0;
      haddr    = 32'h0;
      temp_sel = 3'b000;
      hwdata   = 32'h0;
      pready   = 1'b1;

      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("reset hreadyout", 32'(hreadyout), 32'h1);
      checkOutput("reset psel", 32'(psel), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      hresetn = 1'b1;

      $display("[TB] single read");
      applyStimulus(1'b1, 1'b0, 32'h8000_0010, 3'b001, 32'h0, 1'b1);
      checkOutput("rd idle ready", 32'(hreadyout), 32'h1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("rd setup psel", 32'(psel), 32'h1);
      checkOutput("rd setup penable", 32'(penable), 32'h0);
      checkOutput("rd setup paddr", paddr, 32'h8000_0010);
      checkOutput("rd setup hreadyout", 32'(hreadyout), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("rd access penable", 32'(penable), 32'h1);
      checkOutput("rd access hreadyout", 32'(hreadyout), 32'h1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("rd idle psel", 32'(psel), 32'h0);

      $display("[TB] single write");
      applyStimulus(1'b1, 1'b1, 32'h8400_0004, 3'b010, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'hDEAD_BEEF, 1'b1);
      checkOutput("wr wwait hreadyout", 32'(hreadyout), 32'h1);
      checkOutput("wr wwait psel", 32'(psel), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("wr setup psel", 32'(psel), 32'h2);
      checkOutput("wr setup pwrite", 32'(pwrite), 32'h1);
      checkOutput("wr setup pwdata", pwdata, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("wr access penable", 32'(penable), 32'h1);
      checkOutput("wr access hreadyout", 32'(hreadyout), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("wr idle psel", 32'(psel), 32'h0);
      checkOutput("wr idle paddr kept", paddr, 32'h8400_0004);

      $display("[TB] write then pipelined read");
      applyStimulus(1'b1, 1'b1, 32'h8400_0008, 3'b010, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h8800_0000, 3'b100, 32'h1234_5678, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("wr-rd setup pwdata", pwdata, 32'h1234_5678);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("wr-rd pend psel", 32'(psel), 32'h4);
      checkOutput("wr-rd pend pwrite", 32'(pwrite), 32'h0);
      checkOutput("wr-rd pend paddr", paddr, 32'h8800_0000);
      checkOutput("wr-rd pend hreadyout", 32'(hreadyout), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("wr-rd read done", 32'(hreadyout), 32'h1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);

      $display("[TB] APB wait states");
      applyStimulus(1'b1, 1'b1, 32'h8400_0010, 3'b010, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'hCAFE_0001, 1'b0);
      checkOutput("ws wwait hreadyout", 32'(hreadyout), 32'h1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'hCAFE_0001, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'hCAFE_0001, (i == 3));
         checkOutput("ws hreadyout", 32'(hreadyout), 32'h0);
         checkOutput("ws penable", 32'(penable), 32'h1);
         checkOutput("ws psel", 32'(psel), 32'h2);
         checkOutput("ws paddr", paddr, 32'h8400_0010);
         checkOutput("ws pwdata", pwdata, 32'hCAFE_0001);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("ws idle psel", 32'(psel), 32'h0);

      $display("[TB] back-to-back read, read, write");
      applyStimulus(1'b1, 1'b0, 32'h8000_0020, 3'b001, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h8000_0024, 3'b001, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("b2b rd2 setup paddr", paddr, 32'h8000_0024);
      checkOutput("b2b rd2 setup penable", 32'(penable), 32'h0);
      checkOutput("b2b rd2 setup psel", 32'(psel), 32'h1);
      applyStimulus(1'b1, 1'b1, 32'h8400_0028, 3'b010, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'hB0B0_B0B0, 1'b1);
      checkOutput("b2b wwait psel", 32'(psel), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'hB0B0_B0B0, 1'b1);
      checkOutput("b2b wr setup pwdata", pwdata, 32'hB0B0_B0B0);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);

      $display("[TB] write then pipelined write");
      applyStimulus(1'b1, 1'b1, 32'h8400_0030, 3'b010, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h8000_0034, 3'b001, 32'h1111_1111, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h2222_2222, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h2222_2222, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h2222_2222, 1'b1);
      checkOutput("ww pend wwait hreadyout", 32'(hreadyout), 32'h1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h2222_2222, 1'b1);
      checkOutput("ww pend psel", 32'(psel), 32'h1);
      checkOutput("ww pend pwdata", pwdata, 32'h2222_2222);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);

      $display("[TB] ignored requests");
      applyStimulus(1'b1, 1'b0, 32'h8000_0060, 3'b001, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h8400_0064, 3'b010, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("ign setup psel", 32'(psel), 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h8400_0070, 3'b010, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h3333_3333, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h8800_0074, 3'b100, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h8800_0074, 3'b100, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h8800_0074, 3'b100, 32'h0, 1'b1);
      checkOutput("ign wr access hreadyout", 32'(hreadyout), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("ign no pend psel", 32'(psel), 32'h0);

      $display("[TB] reset mid-access");
      applyStimulus(1'b1, 1'b1, 32'h8400_0040, 3'b010, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h8800_0044, 3'b100, 32'h5555_AAAA, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h5555_AAAA, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h5555_AAAA, 1'b0);
      checkOutput("pre-rst penable", 32'(penable), 32'h1);
      #1;
      hresetn = 1'b0;
      #1;
      checkOutput("async rst psel", 32'(psel), 32'h0);
      checkOutput("async rst penable", 32'(penable), 32'h0);
      checkOutput("async rst hreadyout", 32'(hreadyout), 32'h1);
      checkOutput("async rst pwdata", pwdata, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      hresetn = 1'b1;
      applyStimulus(1'b1, 1'b1, 32'h8400_0050, 3'b010, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h7777_0000, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("post-rst wr paddr", paddr, 32'h8400_0050);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("post-rst no stale pend", 32'(psel), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      checkOutput("post-rst idle psel", 32'(psel), 32'h0);

      applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
